viterbi_decoder: RTL

//  Hard-decision Viterbi decoder for the rate-1/2, K=3 convolutional code (generators 7,5 octal) produced by encoder.

---
 rtl/viterbi_decoder.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/viterbi_decoder.sv
// viterbi_decoder: hard-decision Viterbi decoder for the rate-1/2, K=3 (7,5)
// convolutional code. Four trellis states and register-exchange survivors;
// one decoded bit is produced per accepted symbol after TB_DEPTH symbols.
module viterbi_decoder #(
    parameter int TB_DEPTH = 15,
    parameter int MW       = 6
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       in_valid,
    input  logic [1:0] data_in,
    output logic       data_out,
    output logic       out_valid
);

    localparam int            CW       = $clog2(TB_DEPTH + 1);
    localparam logic [MW-1:0] PM_MAX   = {MW{1'b1}};
    localparam logic [CW-1:0] CNT_MAX  = CW'(TB_DEPTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(TB_DEPTH - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    // The oldest bit of each D-bit survivor is consumed in the same cycle it
    // is formed, so only the newest D-1 decisions are held in flops.
    logic [MW-1:0]       pm_q [4];
    logic [MW-1:0]       pm_d [4];
    logic [TB_DEPTH-2:0] sv_q [4];
    logic [TB_DEPTH-2:0] sv_d [4];
    logic [CW-1:0]       cnt_q, cnt_d;
    logic                data_out_q, data_out_d;
    logic                out_valid_q, out_valid_d;

    logic [MW-1:0]       acs_pm_s [4];
    logic [TB_DEPTH-1:0] acs_sv_s [4];
    logic [MW-1:0]       min_pm_s;
    logic [1:0]          best_s;

    // Hamming distance between two 2-bit symbols (0..2).
    function automatic logic [1:0] hamming(input logic [1:0] a, input logic [1:0] b);
        logic [1:0] x;
        x = a ^ b;
        return {1'b0, x[1]} + {1'b0, x[0]};
    endfunction

    // Path metric plus branch metric, clamped to the all-ones value.
    function automatic logic [MW-1:0] sat_add(input logic [MW-1:0] a, input logic [1:0] b);
        logic [MW:0] s;
        s = {1'b0, a} + {{(MW-1){1'b0}}, b};
        return s[MW] ? PM_MAX : s[MW-1:0];
    endfunction

    // Encoder output for input bit d leaving state {s1,s2}: {g0 (7), g1 (5)}.
    function automatic logic [1:0] exp_sym(input logic d, input logic s1, input logic s2);
        return {d ^ s1 ^ s2, d ^ s2};
    endfunction

    // Add-compare-select for each next state {d,s1}; ties keep the s2=0 predecessor.
    always_comb begin
        logic [1:0]    ns_v;
        logic          dec_v;
        logic          s1_v;
        logic [1:0]    pa_v;
        logic [1:0]    pb_v;
        logic [MW-1:0] ca_v;
        logic [MW-1:0] cb_v;
        ns_v  = 2'd0;
        dec_v = 1'b0;
        s1_v  = 1'b0;
        pa_v  = 2'd0;
        pb_v  = 2'd0;
        ca_v  = '0;
        cb_v  = '0;
        for (int ns = 0; ns < 4; ns++) begin
            ns_v  = 2'(ns);
            dec_v = ns_v[1];
            s1_v  = ns_v[0];
            pa_v  = {s1_v, 1'b0};
            pb_v  = {s1_v, 1'b1};
            ca_v  = sat_add(pm_q[pa_v], hamming(data_in, exp_sym(dec_v, s1_v, 1'b0)));
            cb_v  = sat_add(pm_q[pb_v], hamming(data_in, exp_sym(dec_v, s1_v, 1'b1)));
            if (cb_v < ca_v) begin
                acs_pm_s[ns] = cb_v;
                acs_sv_s[ns] = {sv_q[pb_v], dec_v};
            end else begin
                acs_pm_s[ns] = ca_v;
                acs_sv_s[ns] = {sv_q[pa_v], dec_v};
            end
        end
    end

    // Smallest new metric and its state (lowest index wins ties).
    always_comb begin
        logic lt_v;
        lt_v     = 1'b0;
        min_pm_s = acs_pm_s[0];
        best_s   = 2'd0;
        for (int i = 1; i < 4; i++) begin
            lt_v     = (acs_pm_s[i] < min_pm_s);
            best_s   = lt_v ? 2'(i) : best_s;
            min_pm_s = lt_v ? acs_pm_s[i] : min_pm_s;
        end
    end

    // Next-state: commit normalised metrics, survivors and output on accepted symbols only.
    always_comb begin
        pm_d        = pm_q;
        sv_d        = sv_q;
        cnt_d       = cnt_q;
        data_out_d  = data_out_q;
        out_valid_d = 1'b0;
        if (in_valid) begin
            for (int i = 0; i < 4; i++) begin
                pm_d[i] = acs_pm_s[i] - min_pm_s;
                sv_d[i] = acs_sv_s[i][TB_DEPTH-2:0];
            end
            cnt_d       = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_ONE;
            data_out_d  = acs_sv_s[best_s][TB_DEPTH-1];
            out_valid_d = (cnt_q >= CNT_LAST);
        end else begin
            out_valid_d = 1'b0;
        end
    end

    // State registers with synchronous reset; only state 0 starts reachable.
    always_ff @(posedge clk) begin
        if (reset) begin
            pm_q[0] <= '0;
            pm_q[1] <= PM_MAX;
            pm_q[2] <= PM_MAX;
            pm_q[3] <= PM_MAX;
            for (int i = 0; i < 4; i++) begin
                sv_q[i] <= '0;
            end
            cnt_q       <= '0;
            data_out_q  <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            pm_q        <= pm_d;
            sv_q        <= sv_d;
            cnt_q       <= cnt_d;
            data_out_q  <= data_out_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign data_out  = data_out_q;
    assign out_valid = out_valid_q;

endmodule
